instruction_prefetch_queue: RTL
===============================

// Module: instruction_prefetch_queue
// PURPOSE
//  Prefetch stage upstream of instruction_fetch/decode: issues sequential word fetches on the
//  core memory interface, buffers returned words in a DEPTH-entry FIFO, hands them downstream via
//  valid/ready. Redirect (branch/exception) by flush. The memory answers one cycle after request.
// PARAMETERS
//  DEPTH     4      FIFO entries; power of two, >= 2
//  RESET_PC  32'h0  first fetch address after reset
// PORTS
//  clk         in   1   clock, all state on posedge
//  n_reset     in   1   asynchronous, active-low reset
//  flush_i     in   1   redirect: discard queue + in-flight word, refetch from flush_pc_i
//  flush_pc_i  in   32  redirect target, word aligned
//  stall_i     in   1   data access owns the bus this cycle; issue no request
//  addr_o      out  32  fetch address
//  trans_o     out  2   00 IDLE, 10 NSEQ, 11 SEQ
//  write_o     out  1   constant 0; size_o out 1 constant 1 (word)
//  rdata_i     in   32  read data, valid the cycle after a non-IDLE request
//  abort_i     in   1   fetch abort, qualified like rdata_i
//  instr_o     out  32  head instruction; pc_o out 32 its address
//  valid_o     out  1   head entry valid
//  ready_i     in   1   consumer takes head when valid_o && ready_i
//  abort_o     out  1   head entry aborted (only with PFQ_ABORT_EN)
// BEHAVIOUR
//  - Reset (async): FIFO empty, valid_o=0, pending=0, fetch_pc=RESET_PC, trans_o=00,
//    addr_o=RESET_PC, state=NSEQ. instr_o/pc_o=0. Fetching starts first cycle after release.
//  - Issue when !flush_i && !stall_i && (count + pending) < DEPTH (pop this cycle not credited).
//    trans_o/addr_o combinational from state: addr_o=fetch_pc; trans_o=10 in NSEQ, 11 in SEQ,
//    00 when not issuing. On issue: fetch_pc+=4 (wraps 32'hFFFFFFFC->0), pending<=1, state=SEQ.
//  - Any non-issuing cycle sets state=NSEQ; next request is always NSEQ.
//  - Response: if pending and !flush_i, push {rdata_i, addr, abort_i} at end of that cycle.
//    Address of each in-flight request held in a register for pc_o. pending clears when not issuing.
//  - Pop when valid_o && ready_i; push+pop same cycle: count unchanged. Push never hits full
//    (guaranteed by issue rule). instr_o/pc_o = head; no bypass, no combinational rdata->instr_o.
//  - Latency: request cycle N, captured end N+1, valid_o high cycle N+2.
//  - Flush cycle: trans_o=00, pop ignored, response arriving this cycle dropped; at edge:
//    count=0, pending=0, fetch_pc=flush_pc_i, state=NSEQ. NSEQ to flush_pc_i next cycle;
//    first valid_o 3 cycles after flush. Flush overrides stall_i, ready_i, push.
//  - Stall: no request; response of previous cycle's request still captured.
//  - Reset mid-operation: all state lost, identical to power-on reset.
// CONFIGURATION
//  PFQ_ABORT_EN defined: abort_i stored per entry, presented on abort_o with head. After an aborted
//   word is captured, no further requests (trans_o=00) until flush_i; queue still drains normally.
//  PFQ_ABORT_EN undefined: abort_i ignored, abort_o port absent, fetching never self-halts.
// TESTING
//  1 Reset release, ready_i=1, mem[4k]=k: trans 10@0, 11@4,8,...; instr_o 0,1,2.. from cycle 2, pc_o 0,4,8.
//  2 ready_i=0, DEPTH=4: exactly 4 requests (0..0xC), then trans 00, valid_o=1 held; ready_i=1 ->
//    one pop/cycle, fetching resumes NSEQ at 0x10, no gaps/duplicates.
//  3 Flush flush_pc_i=0x100 with 3 queued + 1 in flight: valid_o=0 next cycle, in-flight word lost,
//    NSEQ 0x100 next cycle, first instr_o=mem[0x100], pc_o=0x100 3 cycles after flush.
//  4 stall_i high 2 cycles mid-stream at 0x20: trans 00 both cycles, 0x1C still captured, resumes NSEQ 0x20.
//  5 flush_i+stall_i+ready_i same cycle with valid_o=1: flush wins, pop not counted, NSEQ to target next.
//  6 PFQ_ABORT_EN, abort_i with word at 0x8: entry 0x8 abort_o=1, trans 00 after, flush to 0x40 resumes.
//  Also: n_reset pulsed mid-stream async-clears valid_o/trans_o; fetch_pc wrap 0xFFFFFFFC->0 SEQ.

Source files
------------

// File: rtl/instruction_prefetch_queue.sv
// Sequential word prefetcher feeding a DEPTH-entry queue; request->valid_o latency 2 cycles, issue throttled by queue+in-flight credit.
// Optional PFQ_ABORT_EN: per-entry abort flag on abort_o, fetching halts after an aborted word until flush_i.
module instruction_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        stall_i,
  output logic [31:0] addr_o,
  output logic [1:0]  trans_o,
  output logic        write_o,
  output logic        size_o,
  input  logic [31:0] rdata_i,
  input  logic        abort_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i
`ifdef PFQ_ABORT_EN
  ,
  output logic        abort_o
`endif
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {ST_NSEQ, ST_SEQ} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          pending;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [CW:0]   occ;
  logic          issue;
  logic          push;
  logic          pop;
  logic          halt;

`ifdef PFQ_ABORT_EN
  logic halted;
  logic q_abort [DEPTH];
  // The capture cycle of an aborted word already blocks the next request.
  assign halt    = halted || (pending && abort_i);
  assign abort_o = q_abort[rd_ptr];
`else
  logic unused_abort;
  assign unused_abort = abort_i;
  assign halt         = 1'b0;
`endif

  // The in-flight word holds a slot; a pop this cycle is not credited.
  assign occ     = {1'b0, count} + {{CW{1'b0}}, pending};
  assign issue   = n_reset && !flush_i && !stall_i && !halt && (occ < (CW+1)'(DEPTH));
  assign push    = pending && !flush_i;
  assign pop     = valid_o && ready_i && !flush_i;

  assign addr_o  = fetch_pc;
  assign trans_o = issue ? {1'b1, state == ST_SEQ} : 2'b00;
  assign write_o = 1'b0;
  assign size_o  = 1'b1;
  assign valid_o = (count != '0);
  assign instr_o = q_instr[rd_ptr];
  assign pc_o    = q_pc[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ST_NSEQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
`ifdef PFQ_ABORT_EN
        q_abort[i] <= 1'b0;
`endif
      end
`ifdef PFQ_ABORT_EN
      halted   <= 1'b0;
`endif
    end else if (flush_i) begin
      state    <= ST_NSEQ;
      fetch_pc <= flush_pc_i;
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
`ifdef PFQ_ABORT_EN
      halted   <= 1'b0;
`endif
    end else begin
      if (issue) begin
        state    <= ST_SEQ;
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
        pending  <= 1'b1;
      end else begin
        state    <= ST_NSEQ;
        pending  <= 1'b0;
      end
      if (push) begin
        q_instr[wr_ptr] <= rdata_i;
        q_pc[wr_ptr]    <= req_pc;
        wr_ptr          <= wr_ptr + AW'(1);
`ifdef PFQ_ABORT_EN
        q_abort[wr_ptr] <= abort_i;
        if (abort_i) halted <= 1'b1;
`endif
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end
endmodule
